// File: rtl/traffic_pkg.sv
// Shared geometry, FSM states, lane record and wrap-aware arithmetic helpers
// for the lane traffic block.
package traffic_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_H    = 120;
    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int CAR_W     = 64;
    localparam int PLAYER_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        CHECK = 2'd2
    } state_t;

    typedef struct packed {
        logic [9:0] car_x;
        logic       dir;
        logic [2:0] speed;
    } lane_t;

    // Single conditional subtract; valid for v < 2*m.
    function automatic logic [9:0] mod_once(input logic [11:0] v, input logic [11:0] m);
        return 10'((v >= m) ? v - m : v);
    endfunction

    // Non-wrapping span [a_lo, a_lo+a_len) against a span starting at b_lo (< m)
    // that may wrap past m-1 back to 0, in which case it is tested as two spans.
    function automatic logic span_overlap(
        input logic [11:0] a_lo,
        input logic [11:0] a_len,
        input logic [11:0] b_lo,
        input logic [11:0] b_len,
        input logic [11:0] m
    );
        logic [12:0] a0, a1, b0, b1, mm;
        a0 = {1'b0, a_lo};
        a1 = a0 + {1'b0, a_len} - 13'd1;
        b0 = {1'b0, b_lo};
        b1 = b0 + {1'b0, b_len} - 13'd1;
        mm = {1'b0, m};
        if (b1 < mm) begin
            return (a0 <= b1) && (b0 <= a1);
        end
        return ((a0 < mm) && (b0 <= a1)) || (a0 <= b1 - mm);
    endfunction

    function automatic logic [9:0] step_x(input lane_t l);
        logic [10:0] sum;
        sum = {1'b0, l.car_x} + 11'(l.speed);
        if (l.dir) begin
            return (sum >= 11'(SCREEN_W)) ? 10'(sum - 11'(SCREEN_W)) : 10'(sum);
        end
        return (l.car_x < 10'(l.speed))
            ? 10'({1'b0, l.car_x} + 11'(SCREEN_W) - 11'(l.speed))
            : l.car_x - 10'(l.speed);
    endfunction

    function automatic lane_t spawn_lane(input logic [15:0] r);
        lane_t l;
        l.car_x = (r[9:0] >= 10'(SCREEN_W)) ? r[9:0] - 10'(SCREEN_W) : r[9:0];
        l.dir   = r[10];
        l.speed = {1'b0, r[12:11]} + 3'd1;
        return l;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11, free-running out of reset.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    logic [15:0] q_d;

    always_comb begin
        q_d = {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= SEED;
        end else begin
            q <= q_d;
        end
    end

endmodule

// File: rtl/lane_traffic.sv
// Follower cars, one per lane: scroll-driven respawn, per-frame stepping, car pixel
// hit and sticky player collision. Optional macro LANE_TRAFFIC_FREEZE_EN freezes the scene after a collision.
module lane_traffic
    import traffic_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       move_followers,
    input  logic [9:0] y_pos,
    input  logic       frame_tick,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic       car_pix,
    output logic       collision,
    output logic       busy
);

    localparam int KW = $clog2(NUM_LANES);

    logic [15:0]   lfsr;
    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    lane_t         lane_q [NUM_LANES];
    lane_t         lane_d [NUM_LANES];
    logic [9:0]    prev_top_q [NUM_LANES];
    logic [9:0]    prev_top_d [NUM_LANES];
    logic          collision_q, collision_d;
    logic          car_pix_q, car_pix_d;
    logic [9:0]    lane_top [NUM_LANES];
    logic [9:0]    body_top [NUM_LANES];
    logic [15:0]   rot [NUM_LANES];
    logic          player_hit;
    logic          frozen;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr)
    );

`ifdef LANE_TRAFFIC_FREEZE_EN
    assign frozen = collision_q;
`else
    assign frozen = 1'b0;
`endif

    // Lane geometry and per-lane LFSR rotations (distinct so simultaneous respawns differ).
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_top[i] = mod_once(12'(i * LANE_H) + {2'b00, y_pos}, 12'(SCREEN_H));
            body_top[i] = mod_once({2'b00, lane_top[i]} + 12'(LANE_H / 4), 12'(SCREEN_H));
            rot[i]      = (lfsr << ((3 * i) % 16)) | (lfsr >> (16 - (3 * i) % 16));
        end
    end

    always_comb begin
        player_hit =
            span_overlap({2'b00, player_x}, 12'(PLAYER_W), {2'b00, lane_q[k_q].car_x},
                         12'(CAR_W), 12'(SCREEN_W)) &&
            span_overlap({2'b00, player_y}, 12'(PLAYER_W), {2'b00, body_top[k_q]},
                         12'(LANE_H / 2), 12'(SCREEN_H));
    end

    always_comb begin
        car_pix_d = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (span_overlap({2'b00, pix_x}, 12'd1, {2'b00, lane_q[i].car_x},
                             12'(CAR_W), 12'(SCREEN_W)) &&
                span_overlap({2'b00, pix_y}, 12'd1, {2'b00, body_top[i]},
                             12'(LANE_H / 2), 12'(SCREEN_H))) begin
                car_pix_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        lane_d      = lane_q;
        prev_top_d  = prev_top_q;
        collision_d = collision_q;
        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d = MOVE;
                end
            end
            MOVE: begin
                state_d = CHECK;
                k_d     = '0;
                if (!frozen) begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        lane_d[i].car_x = step_x(lane_q[i]);
                    end
                end
            end
            CHECK: begin
                if (player_hit) begin
                    collision_d = 1'b1;
                end
                if (k_q == KW'(NUM_LANES - 1)) begin
                    state_d = IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Respawn is applied after the step so it overrides it for a wrapped lane.
        if (move_followers) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                prev_top_d[i] = lane_top[i];
                if ((lane_top[i] < prev_top_q[i]) && !frozen) begin
                    lane_d[i] = spawn_lane(rot[i]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            collision_q <= 1'b0;
            car_pix_q   <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_q[i].car_x <= 10'(i * (SCREEN_W / NUM_LANES));
                lane_q[i].dir   <= 1'(i % 2);
                lane_q[i].speed <= 3'(1 + (i % 4));
                prev_top_q[i]   <= 10'(i * LANE_H);
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            lane_q      <= lane_d;
            prev_top_q  <= prev_top_d;
            collision_q <= collision_d;
            car_pix_q   <= car_pix_d;
        end
    end

    assign car_pix   = car_pix_q;
    assign collision = collision_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lane_traffic.sv
// Randomized bench for lane_traffic against a behavioural scene model.
`timescale 1ns/1ps
module tb_lane_traffic;

    localparam int NL    = 4;
    localparam int LH    = 120;
    localparam int SW    = 640;
    localparam int SH    = 480;
    localparam int CW    = 64;
    localparam int PW    = 32;
    localparam int SEEDV = 'hACE1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       move_followers = 1'b0;
    logic [9:0] y_pos = '0;
    logic       frame_tick = 1'b0;
    logic [9:0] pix_x = '0;
    logic [9:0] pix_y = '0;
    logic [9:0] player_x = '0;
    logic [9:0] player_y = '0;
    logic       car_pix;
    logic       collision;
    logic       busy;

    always #20 clk = ~clk;

    lane_traffic dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .move_followers (move_followers),
        .y_pos          (y_pos),
        .frame_tick     (frame_tick),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .player_x       (player_x),
        .player_y       (player_y),
        .car_pix        (car_pix),
        .collision      (collision),
        .busy           (busy)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Scene model: plain integer positions, a countdown for the update sequence.
    int mx [NL];
    int md [NL];
    int ms [NL];
    int mprev [NL];
    int m_left;
    int m_coll;
    int m_pix;
    int m_lfsr;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int top_of(input int i, input int y);
        return (i * LH + y) % SH;
    endfunction

    function automatic int in_car(input int x, input int y, input int j, input int yp);
        int bt;
        bt = (top_of(j, yp) + LH / 4) % SH;
        return ((((x - mx[j] + SW) % SW) < CW) && (((y - bt + SH) % SH) < LH / 2)) ? 1 : 0;
    endfunction

    function automatic int player_on(input int j, input int px, input int py, input int yp);
        int xo, yo, bt;
        xo = 0;
        yo = 0;
        bt = (top_of(j, yp) + LH / 4) % SH;
        for (int d = 0; d < PW; d++) begin
            if (((px + d - mx[j] + SW) % SW) < CW) xo = 1;
            if (((py + d - bt + SH) % SH) < LH / 2) yo = 1;
        end
        return xo & yo;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NL; i++) begin
            mx[i]    = i * (SW / NL);
            md[i]    = i % 2;
            ms[i]    = 1 + i % 4;
            mprev[i] = i * LH;
        end
        m_left = 0;
        m_coll = 0;
        m_pix  = 0;
        m_lfsr = SEEDV;
    endfunction

    always @(posedge clk) begin
        int hit, frozen, nt, rr, rot, v, yp, pn;
        if (!rst_n) begin
            model_reset();
        end else begin
            yp = int'(y_pos);
            pn = 0;
            for (int j = 0; j < NL; j++) begin
                if (in_car(int'(pix_x), int'(pix_y), j, yp) != 0) pn = 1;
            end
            hit = 0;
            if (m_left >= 1 && m_left <= NL) begin
                hit = player_on(NL - m_left, int'(player_x), int'(player_y), yp);
            end
`ifdef LANE_TRAFFIC_FREEZE_EN
            frozen = m_coll;
`else
            frozen = 0;
`endif
            if (m_left == 0) begin
                if (frame_tick) m_left = NL + 1;
            end else begin
                if (m_left == NL + 1 && frozen == 0) begin
                    for (int i = 0; i < NL; i++) begin
                        mx[i] = (md[i] != 0) ? (mx[i] + ms[i]) % SW : (mx[i] - ms[i] + SW) % SW;
                    end
                end
                m_left--;
            end
            if (move_followers) begin
                for (int i = 0; i < NL; i++) begin
                    nt = top_of(i, yp);
                    if (nt < mprev[i] && frozen == 0) begin
                        rr  = (3 * i) % 16;
                        rot = ((m_lfsr << rr) | (m_lfsr >> (16 - rr))) & 'hFFFF;
                        v   = rot & 1023;
                        mx[i] = (v >= SW) ? v - SW : v;
                        md[i] = (rot >> 10) & 1;
                        ms[i] = 1 + ((rot >> 11) & 3);
                    end
                    mprev[i] = nt;
                end
            end
            m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 'hB400 : 0);
            if (hit != 0) m_coll = 1;
            m_pix = pn;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("car_pix", int'(car_pix), m_pix);
            check("collision", int'(collision), m_coll);
            check("busy", int'(busy), (m_left != 0) ? 1 : 0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int x, input int y, input int exp, input string name);
        pix_x = 10'(x);
        pix_y = 10'(y);
        @(posedge clk);
        @(negedge clk);
        check(name, int'(car_pix), exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt, sx3, j, tp;
        player_x = 10'd600;
        player_y = 10'd440;
        do_reset();
        chk_en = 1'b1;

        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_collision", int'(collision), 0);
        check("reset_car_pix", int'(car_pix), 0);
        for (int i = 0; i < NL; i++) begin
            check("model_reset_x", mx[i], i * 160);
            check("model_reset_dir", md[i], i % 2);
        end
        cyc();

        // Single frame step.
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        check("busy_cycles", cnt, 5);
        cyc();
        check("model_lane1_step", mx[1], 162);
        check("model_lane0_wrap", mx[0], 639);
        probe(162, 160, 1, "pix_lane1_left_edge");
        probe(161, 160, 0, "pix_lane1_before");
        probe(639, 40, 1, "pix_lane0_wrapped");
        probe(63, 40, 0, "pix_lane0_past_end");

        // frame_tick held while busy: only one step.
        frame_tick = 1'b1;
        cyc();
        cyc();
        cyc();
        frame_tick = 1'b0;
        repeat (8) cyc();
        check("model_drop_tick_lane1", mx[1], 164);
        check("model_drop_tick_lane0", mx[0], 638);

        // Scroll wrap respawn.
        move_followers = 1'b1;
        y_pos = 10'd478;
        cyc();
        move_followers = 1'b0;
        cyc();
        sx3 = mx[3];
        move_followers = 1'b1;
        y_pos = 10'd0;
        cyc();
        move_followers = 1'b0;
        check("model_lane3_kept", mx[3], sx3);
        check("model_lane0_speed_range", (ms[0] >= 1 && ms[0] <= 4) ? 1 : 0, 1);
        check("model_lane0_x_range", (mx[0] < SW) ? 1 : 0, 1);
        probe((mx[0] + 5) % SW, 40, 1, "pix_lane0_respawned");

        // Pixel hits and sticky collision from a clean reset.
        do_reset();
        y_pos = 10'd0;
        player_x = 10'd160;
        player_y = 10'd150;
        probe(170, 160, 1, "pix_170_160");
        probe(170, 125, 0, "pix_170_125");
        @(negedge clk);
        check("collision_before_tick", int'(collision), 0);
        cyc();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        repeat (6) cyc();
        @(negedge clk);
        check("collision_set", int'(collision), 1);
        cyc();
        player_x = 10'd0;
        player_y = 10'd400;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        repeat (7) cyc();
        @(negedge clk);
        check("collision_sticky", int'(collision), 1);
        cyc();

`ifdef LANE_TRAFFIC_FREEZE_EN
        sx3 = mx[1];
        repeat (3) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            repeat (7) cyc();
        end
        check("model_frozen_lane1", mx[1], sx3);
        probe(sx3, 160, 1, "pix_frozen_lane1");
`endif

        // Randomized episodes.
        for (int ep = 0; ep < 8; ep++) begin
            y_pos = 10'($urandom_range(0, SH - 1));
            do_reset();
            player_x = 10'($urandom_range(0, SW - PW));
            player_y = 10'($urandom_range(0, SH - PW));
            repeat (700) begin
                rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
                frame_tick = ($urandom_range(0, 15) == 0);
                move_followers = ($urandom_range(0, 5) == 0);
                if (move_followers) begin
                    if ($urandom_range(0, 19) == 0)
                        y_pos = 10'($urandom_range(0, SH - 1));
                    else
                        y_pos = 10'((int'(y_pos) + $urandom_range(1, 8)) % SH);
                end
                if ($urandom_range(0, 1) == 0) begin
                    j  = $urandom_range(0, NL - 1);
                    tp = top_of(j, int'(y_pos));
                    pix_x = 10'((mx[j] + $urandom_range(0, 67) + SW - 2) % SW);
                    pix_y = 10'((tp + $urandom_range(0, 63) + 28) % SH);
                end else begin
                    pix_x = 10'($urandom_range(0, SW - 1));
                    pix_y = 10'($urandom_range(0, SH - 1));
                end
                cyc();
            end
            rst_n = 1'b1;
            frame_tick = 1'b0;
            move_followers = 1'b0;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
